// File: rtl/seg7_pkg.sv
// seg7_pkg: segment encodings, converter states and a decimal range helper
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hFD;
    localparam logic [7:0] SEG_DIGIT [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction
endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: sample strobe/busy handshake plus cathode/anode pins
interface seg7_scan_display_if #(
    parameter int DATA_W = 8,
    parameter int NUM_DIGITS = 8
);
    logic [DATA_W-1:0] data_in;
    logic data_valid;
    logic busy;
    logic [7:0] out_cathode;
    logic [NUM_DIGITS-1:0] out_anode;
    modport master (output data_in, data_valid, input busy, out_cathode, out_anode);
    modport slave (input data_in, data_valid, output busy, out_cathode, out_anode);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: start/done sequential double-dabble converter, one bit per cycle
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_DIGITS = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic [DATA_W-1:0] value,
    output logic busy,
    output logic done,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int CW = $clog2(DATA_W + 1);
    conv_state_t state;
    logic [DATA_W-1:0] bin;
    logic [CW-1:0] cnt;
    logic [4*NUM_DIGITS-1:0] adj;
    assign done = state == COMMIT;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i+:4] = bcd[4*i+:4] > 4'd4 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            cnt <= '0;
            bin <= '0;
            bcd <= '0;
        end else if (state == SHIFT) begin
            {bcd, bin} <= {adj, bin} << 1;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) state <= COMMIT;
        end else if (start) begin
            state <= SHIFT;
            busy <= 1'b1;
            cnt <= '0;
            bin <= value;
            bcd <= '0;
        end else begin
            state <= IDLE;
            busy <= 1'b0;
        end
    end
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: sequential BCD conversion with pending buffer, sign/blank formatting and digit scan
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_DIGITS = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit SIGNED = 1'b1
) (
    input logic clock,
    input logic reset,
    seg7_scan_display_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [63:0] LIM_POS = pow10(NUM_DIGITS);
    localparam logic [63:0] LIM_NEG = pow10(NUM_DIGITS - 1);
    logic conv_busy, conv_done, start, pend_v, use_pend, neg_in, ovf_in;
    logic cur_neg, cur_ovf, disp_neg, disp_ovf;
    logic [DATA_W-1:0] pend, raw, mag;
    logic [4*NUM_DIGITS-1:0] bcd, disp;
    logic [RW-1:0] ref_cnt;
    logic [IW-1:0] idx;
    logic [IW:0] msd;
    logic [3:0] nib;
    logic [7:0] seg;
    assign use_pend = conv_busy | ~bus.data_valid;
    assign start = conv_busy ? conv_done & pend_v : bus.data_valid | pend_v;
    assign raw = use_pend ? pend : bus.data_in;
    assign neg_in = SIGNED & raw[DATA_W-1];
    assign mag = neg_in ? -raw : raw;
    assign ovf_in = 64'(mag) >= (neg_in ? LIM_NEG : LIM_POS);
    assign bus.busy = conv_busy;
    bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) conv (
        .clock(clock),
        .reset(reset),
        .start(start),
        .value(mag),
        .busy(conv_busy),
        .done(conv_done),
        .bcd(bcd)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_v <= 1'b0;
            pend <= '0;
            cur_neg <= 1'b0;
            cur_ovf <= 1'b0;
            disp <= '0;
            disp_neg <= 1'b0;
            disp_ovf <= 1'b0;
        end else begin
            if (bus.data_valid & conv_busy) begin
                pend_v <= 1'b1;
                pend <= bus.data_in;
            end else if (start) begin
                pend_v <= 1'b0;
            end
            if (start) begin
                cur_neg <= neg_in;
                cur_ovf <= ovf_in;
            end
            if (conv_done) begin
                disp <= bcd;
                disp_neg <= cur_neg;
                disp_ovf <= cur_ovf;
            end
        end
    end
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (disp[4*i+:4] != 4'd0) msd = (IW+1)'(i);
    end
    assign nib = disp[4*idx+:4];
    assign seg = disp_ovf ? SEG_MINUS
               : ({1'b0, idx} <= msd) ? SEG_DIGIT[nib]
               : (disp_neg && |disp && {1'b0, idx} == msd + 1'b1) ? SEG_MINUS : SEG_BLANK;
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_cnt <= '0;
            idx <= '0;
            bus.out_anode <= '1;
            bus.out_cathode <= SEG_BLANK;
        end else begin
            ref_cnt <= ref_cnt == RW'(REFRESH_DIV - 1) ? '0 : ref_cnt + 1'b1;
            if (ref_cnt == RW'(REFRESH_DIV - 1)) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            bus.out_anode <= ~(NUM_DIGITS'(1) << idx);
            bus.out_cathode <= seg;
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed and random samples checked against a decimal display model
module tb_seg7_scan_display;
    localparam int RD = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    always #5 clock = ~clock;
    seg7_scan_display_if #(.DATA_W(8), .NUM_DIGITS(4)) b1 ();
    seg7_scan_display_if #(.DATA_W(8), .NUM_DIGITS(2)) b2 ();
    seg7_scan_display #(.DATA_W(8), .NUM_DIGITS(4), .REFRESH_DIV(RD), .SIGNED(1'b1)) dut1 (
        .clock(clock), .reset(reset), .bus(b1));
    seg7_scan_display #(.DATA_W(8), .NUM_DIGITS(2), .REFRESH_DIV(RD), .SIGNED(1'b0)) dut2 (
        .clock(clock), .reset(reset), .bus(b2));
    function automatic logic [7:0] exp_seg(input int value, input bit sg, input int n, input int pos);
        int v, mag, lim, len, d;
        v = (sg && value > 127) ? value - 256 : value;
        mag = v < 0 ? -v : v;
        lim = 1;
        for (int i = 0; i < n; i++) lim *= 10;
        len = 1;
        for (int t = mag; t >= 10; t /= 10) len++;
        d = mag;
        for (int i = 0; i < pos; i++) d /= 10;
        if (mag >= lim || (v < 0 && mag >= lim / 10)) return 8'hFD;
        if (pos < len) return seg_tab[d % 10];
        if (v < 0 && pos == len) return 8'hFD;
        return 8'hFF;
    endfunction
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic strobe(input bit which, input logic [7:0] value);
        @(negedge clock);
        if (which) begin
            b2.data_in = value;
            b2.data_valid = 1'b1;
        end else begin
            b1.data_in = value;
            b1.data_valid = 1'b1;
        end
        @(negedge clock);
        b1.data_valid = 1'b0;
        b2.data_valid = 1'b0;
    endtask
    task automatic wait_idle(input bit which);
        int n = 0;
        while ((which ? b2.busy : b1.busy) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", 16'(n < 100), 16'd1);
    endtask
    task automatic check_disp(input bit which, input int value);
        int n = which ? 2 : 4;
        int pos;
        logic [7:0] an, ca;
        repeat (2) @(negedge clock);
        for (int c = 0; c < n * RD; c++) begin
            an = which ? {6'h3F, b2.out_anode} : {4'hF, b1.out_anode};
            ca = which ? b2.out_cathode : b1.out_cathode;
            pos = -1;
            for (int i = 0; i < n; i++) if (an == ~(8'd1 << i)) pos = i;
            chk("anode_onehot", 16'(pos >= 0), 16'd1);
            if (pos >= 0)
                chk($sformatf("dut%0d_digit%0d_of_%0d", which + 1, pos, value), {8'h0, ca},
                    {8'h0, exp_seg(value, !which, n, pos)});
            @(negedge clock);
        end
    endtask
    initial begin
        logic [3:0] ea;
        int run, v;
        bit seen;
        b1.data_in = '0;
        b1.data_valid = 1'b0;
        b2.data_in = '0;
        b2.data_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_anode", 16'(b1.out_anode), 16'hF);
        chk("rst_cathode", 16'(b1.out_cathode), 16'hFF);
        chk("rst_busy", 16'(b1.busy), 16'h0);
        chk("rst_anode2", 16'(b2.out_anode), 16'h3);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            ea = ~(4'b0001 << (((k - 1) / RD) % 4));
            chk("scan_anode", 16'(b1.out_anode), 16'(ea));
            chk("scan_cathode", 16'(b1.out_cathode), (((k - 1) / RD) % 4 == 0) ? 16'h03 : 16'hFF);
        end
        strobe(0, 8'd25);
        run = 0;
        while (b1.busy && run < 40) begin
            run++;
            @(negedge clock);
        end
        chk("busy_len_single", 16'(run), 16'd9);
        check_disp(0, 25);
        strobe(0, 8'hE9);
        wait_idle(0);
        check_disp(0, 'hE9);
        strobe(0, 8'd23);
        run = 0;
        for (int k = 0; k < 40 && b1.busy; k++) begin
            run++;
            b1.data_valid = (k == 2 || k == 4);
            b1.data_in = (k == 2) ? 8'd24 : 8'd25;
            @(negedge clock);
        end
        b1.data_valid = 1'b0;
        chk("busy_len_pending", 16'(run), 16'd18);
        check_disp(0, 25);
        foreach (seg_tab[i]) begin
            if (i < 4) begin
                v = (i == 0) ? 'h80 : (i == 1) ? 0 : (i == 2) ? 'hFF : 'h7F;
                strobe(0, 8'(v));
                wait_idle(0);
                check_disp(0, v);
            end
        end
        for (int r = 0; r < 6; r++) begin
            v = $urandom_range(0, 255);
            strobe(0, 8'(v));
            wait_idle(0);
            check_disp(0, v);
        end
        for (int r = 0; r < 8; r++) begin
            v = (r == 0) ? 200 : (r == 1) ? 99 : (r == 2) ? 100 : (r == 3) ? 0 : $urandom_range(0, 255);
            strobe(1, 8'(v));
            wait_idle(1);
            check_disp(1, v);
        end
        strobe(0, 8'd77);
        repeat (2) @(negedge clock);
        strobe(0, 8'd99);
        chk("busy_before_reset", 16'(b1.busy), 16'h1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", 16'(b1.busy), 16'h0);
        chk("midrst_anode", 16'(b1.out_anode), 16'hF);
        chk("midrst_cathode", 16'(b1.out_cathode), 16'hFF);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            seen |= b1.busy;
        end
        chk("pending_discarded", 16'(seen), 16'h0);
        check_disp(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
